// File: rtl/cz80_lockstep_checker.sv
// cz80_lockstep_checker: lockstep comparator for two Z80 decoder/microcode implementations
//
// Every accepted beat carries one stimulus tag and two packed result vectors. The block
// compares the vectors outside the don't-care mask and counts compares and mismatches.
// It records the tag and diff of the first mismatch. It can stop taking beats after a
// mismatch.
//
// Pipeline: stage 1 registers the beat. The stage 2 load edge registers the masked diff and
// updates the counters and captures. o_err is therefore visible two cycles after accept.
//
// Optional feature (macro CZ80_CHECKER_LAST_CAPTURE_EN): adds o_last_tag/o_last_diff. They
// hold the most recent mismatch and are zeroed by reset and by clear.
//
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_clear                   sync clear: flush pipeline, zero counters/captures, back to RUN
//   i_halt_on_err             stop accepting beats once a mismatch leaves stage 2
//   i_valid / o_ready         beat handshake (accept = i_valid & o_ready)
//   i_tag, i_res_a, i_res_b   stimulus tag and the two result vectors
//   i_mask                    1 = don't-care bit
//   o_err                     one-cycle pulse per mismatching beat
//   o_err_sticky              any mismatch since reset/clear
//   o_first_tag, o_first_diff tag and masked diff of the earliest mismatch
//   o_cmp_count, o_err_count  saturating beat and mismatch counters
//   o_halted                  intake stopped after a mismatch
module cz80_lockstep_checker #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 25,
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_clear,
    input  logic             i_halt_on_err,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [TAG_W-1:0] i_tag,
    input  logic [WIDTH-1:0] i_res_a,
    input  logic [WIDTH-1:0] i_res_b,
    input  logic [WIDTH-1:0] i_mask,
    output logic             o_err,
    output logic             o_err_sticky,
    output logic [TAG_W-1:0] o_first_tag,
    output logic [WIDTH-1:0] o_first_diff,
    output logic [CNT_W-1:0] o_cmp_count,
    output logic [CNT_W-1:0] o_err_count,
`ifdef CZ80_CHECKER_LAST_CAPTURE_EN
    output logic [TAG_W-1:0] o_last_tag,
    output logic [WIDTH-1:0] o_last_diff,
`endif
    output logic             o_halted
);
    typedef enum logic {RUN, HALT} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_v1, r_v2;
    logic [TAG_W-1:0]   r_tag1;
    logic [WIDTH-1:0]   r_a1, r_b1, r_m1, r_diff2;
    logic [WIDTH-1:0]   w_diff1;
    logic               w_mis1, w_mis2, w_acc;

    assign w_acc   = i_valid & o_ready & ~i_clear;
    assign w_diff1 = (r_a1 ^ r_b1) & ~r_m1;
    assign w_mis1  = |w_diff1;
    assign w_mis2  = |r_diff2;
    assign o_err   = r_v2 & w_mis2;

    always_comb begin
        w_state_nxt = r_state;
        o_ready     = r_state == RUN;
        o_halted    = r_state == HALT;
        if (i_clear)
            w_state_nxt = RUN;
        else if (r_state == RUN && o_err && i_halt_on_err)
            w_state_nxt = HALT;
    end

    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) r_state <= RUN;
        else            r_state <= w_state_nxt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_tag1       <= '0;
            r_a1         <= '0;
            r_b1         <= '0;
            r_m1         <= '0;
            r_diff2      <= '0;
            o_err_sticky <= 1'b0;
            o_first_tag  <= '0;
            o_first_diff <= '0;
            o_cmp_count  <= '0;
            o_err_count  <= '0;
`ifdef CZ80_CHECKER_LAST_CAPTURE_EN
            o_last_tag   <= '0;
            o_last_diff  <= '0;
`endif
        end else begin
            r_v1 <= w_acc;
            if (w_acc) begin
                r_tag1 <= i_tag;
                r_a1   <= i_res_a;
                r_b1   <= i_res_b;
                r_m1   <= i_mask;
            end
            r_v2    <= r_v1 & ~i_clear;
            r_diff2 <= w_diff1;
            if (i_clear) begin
                o_err_sticky <= 1'b0;
                o_first_tag  <= '0;
                o_first_diff <= '0;
                o_cmp_count  <= '0;
                o_err_count  <= '0;
`ifdef CZ80_CHECKER_LAST_CAPTURE_EN
                o_last_tag   <= '0;
                o_last_diff  <= '0;
`endif
            end else if (r_v1) begin
                o_cmp_count <= &o_cmp_count ? o_cmp_count : o_cmp_count + CNT_W'(1);
                if (w_mis1) begin
                    o_err_count  <= &o_err_count ? o_err_count : o_err_count + CNT_W'(1);
                    o_err_sticky <= 1'b1;
                    // Captures freeze after the first mismatch so the earliest beat wins.
                    if (!o_err_sticky) begin
                        o_first_tag  <= r_tag1;
                        o_first_diff <= w_diff1;
                    end
`ifdef CZ80_CHECKER_LAST_CAPTURE_EN
                    o_last_tag  <= r_tag1;
                    o_last_diff <= w_diff1;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_cz80_lockstep_checker.sv
// tb_cz80_lockstep_checker: randomized scoreboard bench for cz80_lockstep_checker
module tb_cz80_lockstep_checker;
    localparam int WIDTH = 64;
    localparam int TAG_W = 25;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0, halt_on_err = 1'b0, valid = 1'b0;
    logic             ready, err, err_sticky, halted;
    logic [TAG_W-1:0] tag = '0, first_tag;
    logic [WIDTH-1:0] res_a = '0, res_b = '0, mask = '0, first_diff;
    logic [CNT_W-1:0] cmp_count, err_count;
`ifdef CZ80_CHECKER_LAST_CAPTURE_EN
    logic [TAG_W-1:0] last_tag;
    logic [WIDTH-1:0] last_diff;
`endif

    cz80_lockstep_checker #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_clear(clear), .i_halt_on_err(halt_on_err),
        .i_valid(valid), .o_ready(ready), .i_tag(tag), .i_res_a(res_a), .i_res_b(res_b),
        .i_mask(mask), .o_err(err), .o_err_sticky(err_sticky), .o_first_tag(first_tag),
        .o_first_diff(first_diff), .o_cmp_count(cmp_count), .o_err_count(err_count),
`ifdef CZ80_CHECKER_LAST_CAPTURE_EN
        .o_last_tag(last_tag), .o_last_diff(last_diff),
`endif
        .o_halted(halted));

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard entry: a beat becomes visible on the outputs at negedge of cycle 'due'.
    typedef struct { int due; logic [TAG_W-1:0] tag; logic [WIDTH-1:0] diff; } beat_t;
    beat_t q[$];

    // Reference model of the observable state.
    int               m_cmp, m_errc;
    bit               m_sticky, m_halted, m_err;
    logic [TAG_W-1:0] m_ftag, m_ltag;
    logic [WIDTH-1:0] m_fdiff, m_ldiff;
    beat_t            b;

    function automatic int sat(input int v);
        return v == CMAX ? v : v + 1;
    endfunction

    task automatic model_reset();
        m_cmp = 0; m_errc = 0; m_sticky = 0; m_halted = 0; m_err = 0;
        m_ftag = '0; m_ltag = '0; m_fdiff = '0; m_ldiff = '0;
        q.delete();
    endtask

    always @(negedge clk) begin
        if (!rst_n) model_reset();
        else begin
            m_err = 0;
            if (q.size() > 0 && q[0].due == cyc) begin
                b = q.pop_front();
                m_cmp = sat(m_cmp);
                if (b.diff != '0) begin
                    m_err = 1;
                    m_errc = sat(m_errc);
                    if (!m_sticky) begin m_ftag = b.tag; m_fdiff = b.diff; end
                    m_sticky = 1;
                    m_ltag = b.tag; m_ldiff = b.diff;
                end
            end
            check("err", err, m_err);
            check("err_sticky", err_sticky, m_sticky);
            check("first_tag", first_tag, m_ftag);
            check("first_diff", first_diff, m_fdiff);
            check("cmp_count", cmp_count, m_cmp);
            check("err_count", err_count, m_errc);
            check("ready", ready, !m_halted);
            check("halted", halted, m_halted);
`ifdef CZ80_CHECKER_LAST_CAPTURE_EN
            check("last_tag", last_tag, m_ltag);
            check("last_diff", last_diff, m_ldiff);
`endif
            if (clear) model_reset();
            else if (m_err && halt_on_err) m_halted = 1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Hold a beat on the inputs until accepted or the try budget runs out.
    task automatic send(input logic [TAG_W-1:0] t, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] bb, input logic [WIDTH-1:0] m, output bit ok);
        valid = 1; tag = t; res_a = a; res_b = bb; mask = m; ok = 0;
        for (int i = 0; i < 8 && !ok; i++) begin
            if (ready && !clear) begin
                q.push_back('{due: cyc + 2, tag: t, diff: (a ^ bb) & ~m});
                ok = 1;
            end
            @(posedge clk); #1;
        end
        valid = 0;
    endtask

    task automatic do_clear();
        clear = 1; step(1); clear = 0;
    endtask

    function automatic logic [WIDTH-1:0] r64();
        return {$urandom, $urandom};
    endfunction

    logic [WIDTH-1:0] a, d, m;
    bit ok;
    int acc;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        rst_n = 1;
        check("reset_ready", ready, 1);
        check("reset_cmp", cmp_count, 0);
        step(2);

        // Clean stream.
        for (int i = 1; i <= 10; i++) begin a = r64(); send(TAG_W'(i), a, a, '0, ok); end
        step(4);
        check("clean_cmp", cmp_count, 10);
        check("clean_errc", err_count, 0);

        // Single mismatch at beat 4, no halt.
        do_clear();
        for (int i = 1; i <= 10; i++) begin
            a = r64();
            send(i == 4 ? TAG_W'(25'h000123) : TAG_W'(i), a, i == 4 ? a ^ 64'h20 : a, '0, ok);
        end
        step(4);
        check("one_ftag", first_tag, 25'h000123);
        check("one_fdiff", first_diff, 64'h20);
        check("one_errc", err_count, 1);
        check("one_cmp", cmp_count, 10);

        // Same stimulus with halt enabled.
        do_clear();
        halt_on_err = 1;
        acc = 0;
        for (int i = 1; i <= 10; i++) begin
            a = r64();
            send(i == 4 ? TAG_W'(25'h000123) : TAG_W'(i), a, i == 4 ? a ^ 64'h20 : a, '0, ok);
            if (!ok) break;
            acc++;
        end
        step(3);
        check("halt_accepted", acc, 6);
        check("halt_halted", halted, 1);
        check("halt_ready", ready, 0);
        check("halt_cmp", cmp_count, 6);
        halt_on_err = 0;
        step(3);
        check("halt_hold", halted, 1);
        do_clear();
        check("clr_cmp", cmp_count, 0);
        check("clr_errc", err_count, 0);
        check("clr_ready", ready, 1);

        // Mismatch only in masked bit 63.
        for (int i = 0; i < 5; i++) begin
            a = r64(); send(TAG_W'(i), a, a ^ 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, ok);
        end
        step(4);
        check("mask_sticky", err_sticky, 0);
        check("mask_cmp", cmp_count, 5);

        // Two mismatches: earliest wins the first capture.
        do_clear();
        for (int i = 1; i <= 10; i++) begin
            a = r64(); d = r64() | 64'h1;
            send(TAG_W'(i), a, (i == 5 || i == 9) ? a ^ d : a, '0, ok);
        end
        step(4);
        check("two_ftag", first_tag, 5);
        check("two_errc", err_count, 2);
`ifdef CZ80_CHECKER_LAST_CAPTURE_EN
        check("two_ltag", last_tag, 9);
`endif

        // Saturation of the narrow counters.
        do_clear();
        for (int i = 0; i < 20; i++) begin a = r64(); send(TAG_W'(i), a, a ^ r64(), '0, ok); end
        step(4);
        check("sat_cmp", cmp_count, CMAX);
        check("sat_errc", err_count, CMAX);

        // Randomized traffic with bubbles, masks, halts and clears.
        do_clear();
        for (int i = 0; i < 400; i++) begin
            halt_on_err = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) do_clear();
            else if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
            else begin
                a = r64();
                case ($urandom_range(0, 3))
                    0: m = '1;
                    1: m = r64();
                    default: m = '0;
                endcase
                d = ($urandom_range(0, 2) == 0) ? (64'h1 << $urandom_range(0, 63)) : '0;
                send(TAG_W'($urandom), a, a ^ d, m, ok);
            end
        end
        halt_on_err = 0;
        do_clear();

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) begin a = r64(); send(TAG_W'(i + 1), a, a ^ 64'h4, '0, ok); end
        #2 rst_n = 0;
        #1;
        check("areset_cmp", cmp_count, 0);
        check("areset_errc", err_count, 0);
        check("areset_sticky", err_sticky, 0);
        check("areset_ftag", first_tag, 0);
        check("areset_ready", ready, 1);
        @(posedge clk); #3 rst_n = 1;
        step(1);
        for (int i = 0; i < 3; i++) begin a = r64(); send(TAG_W'(i), a, a, '0, ok); end
        step(4);
        check("post_reset_cmp", cmp_count, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
